// File: rtl/leak_observer_2bit_if.sv
// ============================================================================
// leak_observer_2bit_if : valid/ready channel carrying recovered asset bits
// Revision: 1.0
// ============================================================================
`default_nettype none

interface leak_observer_2bit_if;
  logic rx_bit;
  logic rx_valid;
  logic rx_ready;

  modport master (output rx_bit, output rx_valid, input rx_ready);
  modport slave  (input rx_bit, input rx_valid, output rx_ready);
endinterface

`default_nettype wire

// File: rtl/leak_observer_2bit.sv
// ============================================================================
// leak_observer_2bit : frame-locks the period-4 leak stream, checks the
// constant bits, recovers the asset bit and gathers per-window ones counts.
// Revision: 1.0
// ============================================================================
`default_nettype none

module leak_observer_2bit #(
  parameter  int MAX_ERR = 3,
  parameter  int WINDOW  = 16,
  parameter  int ERR_W   = 8,
  localparam int WIN_W   = $clog2(WINDOW + 1)
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic [1:0]            din_i,
  leak_observer_2bit_if.master       rx_if,
  output logic                       locked_o,
  output logic                       lock_lost_o,
  output logic [ERR_W-1:0]           err_cnt_o,
  output logic                       overflow_o,
  output logic [WIN_W-1:0]           window_ones_o,
  output logic                       window_done_o
);

  localparam int CE_W = $clog2(MAX_ERR + 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q;
  logic [1:0]         prev_q;
  logic [1:0]         phase_q;
  logic [CE_W-1:0]    consec_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [WIN_W-1:0]   win_ones_q;
  logic               rx_bit_q;
  logic               rx_valid_q;
  logic               locked_q;
  logic               lock_lost_q;
  logic [ERR_W-1:0]   err_cnt_q;
  logic               overflow_q;
  logic [WIN_W-1:0]   window_ones_q;
  logic               window_done_q;

  logic               sample_ok;
  logic               capture;
  logic [CE_W-1:0]    consec_d;
  logic [WIN_W-1:0]   win_cnt_d;
  logic [WIN_W-1:0]   win_ones_d;

  // Phase 3 carries {1, asset}: only the marker bit is checked.
  always_comb begin
    sample_ok = 1'b0;
    unique case (phase_q)
      2'd1, 2'd2: sample_ok = (din_i == 2'b11);
      2'd3:       sample_ok = din_i[1];
      default:    sample_ok = (din_i == 2'b00);
    endcase
    capture    = (state_q == LOCKED) && (phase_q == 2'd3) && din_i[1];
    consec_d   = consec_q + CE_W'(1);
    win_cnt_d  = win_cnt_q + WIN_W'(1);
    win_ones_d = win_ones_q + WIN_W'(din_i[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      prev_q        <= 2'b11;
      phase_q       <= 2'd0;
      consec_q      <= '0;
      win_cnt_q     <= '0;
      win_ones_q    <= '0;
      rx_bit_q      <= 1'b0;
      rx_valid_q    <= 1'b0;
      locked_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
      err_cnt_q     <= '0;
      overflow_q    <= 1'b0;
      window_ones_q <= '0;
      window_done_q <= 1'b0;
    end else begin
      prev_q        <= din_i;
      lock_lost_q   <= 1'b0;
      window_done_q <= 1'b0;

      case (state_q)
        HUNT: begin
          // The 11 that follows a 00 is phase 1 of the frame.
          if (prev_q == 2'b00 && din_i == 2'b11) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            phase_q  <= 2'd2;
            consec_q <= '0;
          end
        end
        LOCKED: begin
          phase_q <= phase_q + 2'd1;
          if (sample_ok) begin
            consec_q <= '0;
          end else begin
            if (err_cnt_q != '1)
              err_cnt_q <= err_cnt_q + ERR_W'(1);
            if (consec_d == CE_W'(MAX_ERR)) begin
              state_q     <= HUNT;
              locked_q    <= 1'b0;
              lock_lost_q <= 1'b1;
              consec_q    <= '0;
            end else begin
              consec_q <= consec_d;
            end
          end
        end
        default: state_q <= HUNT;
      endcase

      if (capture) begin
        if (!rx_valid_q || rx_if.rx_ready) begin
          rx_bit_q   <= din_i[0];
          rx_valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
        // Dropped bits still count toward the window.
        if (win_cnt_d == WIN_W'(WINDOW)) begin
          window_ones_q <= win_ones_d;
          window_done_q <= 1'b1;
          win_cnt_q     <= '0;
          win_ones_q    <= '0;
        end else begin
          win_cnt_q  <= win_cnt_d;
          win_ones_q <= win_ones_d;
        end
      end else if (rx_valid_q && rx_if.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_bit   = rx_bit_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign locked_o       = locked_q;
  assign lock_lost_o    = lock_lost_q;
  assign err_cnt_o      = err_cnt_q;
  assign overflow_o     = overflow_q;
  assign window_ones_o  = window_ones_q;
  assign window_done_o  = window_done_q;

endmodule

`default_nettype wire

// File: tb/tb_leak_observer_2bit.sv
// ============================================================================
// tb_leak_observer_2bit : directed vector table plus hand sequences for
// lock, error, handshake, window and reset behaviour.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_leak_observer_2bit;

  logic       clk;
  logic       reset;
  logic [1:0] din;
  logic       locked;
  logic       lock_lost;
  logic [7:0] err_cnt;
  logic       overflow;
  logic [4:0] window_ones;
  logic       window_done;

  leak_observer_2bit_if rxif ();

  leak_observer_2bit #(
    .MAX_ERR (3),
    .WINDOW  (16),
    .ERR_W   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .din_i         (din),
    .rx_if         (rxif),
    .locked_o      (locked),
    .lock_lost_o   (lock_lost),
    .err_cnt_o     (err_cnt),
    .overflow_o    (overflow),
    .window_ones_o (window_ones),
    .window_done_o (window_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [1:0] din;
    logic       rdy;
    logic       e_locked;
    logic       e_valid;
    logic       e_bit;
    logic [7:0] e_err;
    logic       e_lost;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] d, input logic rd,
                     input logic el, input logic ev, input logic eb,
                     input logic [7:0] ee, input logic elost, input logic eovf);
    vec_t v;
    v.rst = r; v.din = d; v.rdy = rd;
    v.e_locked = el; v.e_valid = ev; v.e_bit = eb;
    v.e_err = ee; v.e_lost = elost; v.e_ovf = eovf;
    vecs.push_back(v);
  endtask

  // Inputs change 1 time unit after the active edge; outputs are read there too.
  task automatic step(input logic r, input logic [1:0] d, input logic rd);
    reset = r;
    din   = d;
    rxif.rx_ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       assets [8];
    logic       lastb;
    logic [15:0] m1;
    logic [15:0] m2;

    reset = 1'b1;
    din   = 2'b00;
    rxif.rx_ready = 1'b0;

    // ---- vector table ----
    add(1, 2'b00, 1, 0, 0, 0, 8'd0, 0, 0);
    add(0, 2'b00, 1, 0, 0, 0, 8'd0, 0, 0);
    assets = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    lastb = 1'b0;
    for (int f = 0; f < 8; f++) begin
      add(0, 2'b11, 1, 1, 0, lastb, 8'd0, 0, 0);
      add(0, 2'b11, 1, 1, 0, lastb, 8'd0, 0, 0);
      add(0, {1'b1, assets[f]}, 1, 1, 1, assets[f], 8'd0, 0, 0);
      add(0, 2'b00, 1, 1, 0, assets[f], 8'd0, 0, 0);
      lastb = assets[f];
    end
    // three consecutive bad samples drop lock
    add(0, 2'b01, 1, 1, 0, 1, 8'd1, 0, 0);
    add(0, 2'b01, 1, 1, 0, 1, 8'd2, 0, 0);
    add(0, 2'b01, 1, 0, 0, 1, 8'd3, 1, 0);
    add(0, 2'b11, 1, 0, 0, 1, 8'd3, 0, 0);
    add(0, 2'b00, 1, 0, 0, 1, 8'd3, 0, 0);
    add(0, 2'b11, 1, 1, 0, 1, 8'd3, 0, 0);
    add(0, 2'b11, 1, 1, 0, 1, 8'd3, 0, 0);
    add(0, 2'b10, 1, 1, 1, 0, 8'd3, 0, 0);
    add(0, 2'b00, 1, 1, 0, 0, 8'd3, 0, 0);
    // isolated errors separated by good samples keep lock
    add(0, 2'b01, 1, 1, 0, 0, 8'd4, 0, 0);
    add(0, 2'b11, 1, 1, 0, 0, 8'd4, 0, 0);
    add(0, 2'b11, 1, 1, 1, 1, 8'd4, 0, 0);
    add(0, 2'b01, 1, 1, 0, 1, 8'd5, 0, 0);
    add(0, 2'b01, 1, 1, 0, 1, 8'd6, 0, 0);
    add(0, 2'b11, 1, 1, 0, 1, 8'd6, 0, 0);
    add(0, 2'b01, 1, 1, 0, 1, 8'd7, 0, 0);
    add(0, 2'b00, 1, 1, 0, 1, 8'd7, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].din, vecs[i].rdy);
      chk($sformatf("vec[%0d] {lock,valid,bit,err,lost,ovf}", i),
          {19'd0, locked, rxif.rx_valid, rxif.rx_bit, err_cnt, lock_lost, overflow},
          {19'd0, vecs[i].e_locked, vecs[i].e_valid, vecs[i].e_bit, vecs[i].e_err,
           vecs[i].e_lost, vecs[i].e_ovf});
    end

    // ---- reset mid-frame with a pending bit ----
    step(0, 2'b11, 0);
    step(0, 2'b11, 0);
    step(0, 2'b10, 0);
    chk("pending bit before reset {valid,bit}", {30'd0, rxif.rx_valid, rxif.rx_bit}, 32'd2);
    step(1, 2'b11, 0);
    chk("outputs in reset",
        {14'd0, locked, rxif.rx_valid, rxif.rx_bit, err_cnt, lock_lost, overflow, window_ones, window_done},
        32'd0);
    step(0, 2'b11, 0);
    chk("no lock on 11 after reset", {31'd0, locked}, 32'd0);
    step(0, 2'b11, 0);
    chk("no lock on 11 after 11", {31'd0, locked}, 32'd0);
    step(0, 2'b00, 0);
    chk("no lock on 00", {31'd0, locked}, 32'd0);
    step(0, 2'b11, 0);
    chk("lock on 00->11", {31'd0, locked}, 32'd1);

    // ---- window statistics: two consecutive windows ----
    m1 = 16'h8189;   // 5 ones
    m2 = 16'h0604;   // 3 ones
    step(1, 2'b00, 1);
    step(0, 2'b00, 1);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) begin
        logic a;
        a = (w == 0) ? m1[i] : m2[i];
        step(0, 2'b11, 1);
        step(0, 2'b11, 1);
        step(0, {1'b1, a}, 1);
        chk($sformatf("window_done w%0d f%0d", w, i), {31'd0, window_done},
            (i == 15) ? 32'd1 : 32'd0);
        if (i == 15)
          chk($sformatf("window_ones w%0d", w), {27'd0, window_ones},
              (w == 0) ? 32'd5 : 32'd3);
        if (i == 14)
          chk($sformatf("window_ones held w%0d", w), {27'd0, window_ones},
              (w == 0) ? 32'd0 : 32'd5);
        step(0, 2'b00, 1);
        if (i == 15)
          chk($sformatf("window_done pulse ends w%0d", w), {31'd0, window_done}, 32'd0);
      end
    end

    // ---- back-pressure and overflow ----
    step(0, 2'b11, 0);
    step(0, 2'b11, 0);
    step(0, 2'b11, 0);
    chk("held capture {valid,bit,ovf}", {29'd0, rxif.rx_valid, rxif.rx_bit, overflow}, 32'd6);
    step(0, 2'b00, 0);
    step(0, 2'b11, 0);
    step(0, 2'b11, 0);
    step(0, 2'b10, 0);
    chk("drop keeps old bit {valid,bit,ovf}", {29'd0, rxif.rx_valid, rxif.rx_bit, overflow}, 32'd7);
    step(0, 2'b00, 0);
    chk("still held {valid,bit}", {30'd0, rxif.rx_valid, rxif.rx_bit}, 32'd3);
    step(0, 2'b11, 1);
    chk("delivered {valid,ovf}", {30'd0, rxif.rx_valid, overflow}, 32'd1);
    chk("err_cnt clean run", {24'd0, err_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
